victim_cache_slot_decoder: RTL and testbench

VICTIM_CACHE_SLOT_DECODER -- requirements
Module: victim_cache_slot_decoder

---
 rtl/victim_cache_slot_decoder.sv | 168 ++++++++++++++++
 tb/tb_victim_cache_slot_decoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/victim_cache_slot_decoder.sv
// ---------------------------------------------------------------------------
// victim_cache_slot_decoder
//
// Turns victim-cache requests into a registered one-hot and binary entry
// select, and tracks which entries are allocated.
//   HIT   : select i_req_index, bitmap unchanged
//   ALLOC : select the lowest free entry and mark it valid; if every entry is
//           valid, select the round-robin pointer entry and advance the pointer
//   INVAL : select i_req_index and clear its valid bit
//   op 11 : accepted, empty select, no state change
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   i_flush         synchronous clear of bitmap, pointer and pending result
//   i_req_valid     request handshake (o_req_ready is the ready side)
//   i_req_op        request type
//   i_req_index     entry index for HIT / INVAL
//   o_sel_valid     result handshake (i_sel_ready is the ready side)
//   o_sel_onehot    one-hot entry select
//   o_sel_index     binary entry select
//   o_sel_op        echo of the accepted op
//   o_valid_map     current entry-valid bitmap
// ---------------------------------------------------------------------------
module victim_cache_slot_decoder #(
    parameter int N_ENTRIES = 16,
    parameter int IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_flush,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [1:0]           i_req_op,
    input  logic [IDX_W-1:0]     i_req_index,
    output logic                 o_sel_valid,
    input  logic                 i_sel_ready,
    output logic [N_ENTRIES-1:0] o_sel_onehot,
    output logic [IDX_W-1:0]     o_sel_index,
    output logic [1:0]           o_sel_op,
    output logic [N_ENTRIES-1:0] o_valid_map
);

    localparam logic [1:0] OP_HIT   = 2'b00;
    localparam logic [1:0] OP_ALLOC = 2'b01;
    localparam logic [1:0] OP_INVAL = 2'b10;

    // Binary index to one-hot entry mask.
    function automatic logic [N_ENTRIES-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        idx_to_onehot = {{(N_ENTRIES-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic [N_ENTRIES-1:0] bitmap_r;
    logic [IDX_W-1:0]     ptr_r;
    logic                 sel_valid_r;
    logic [N_ENTRIES-1:0] sel_onehot_r;
    logic [IDX_W-1:0]     sel_index_r;
    logic [1:0]           sel_op_r;

    logic [N_ENTRIES-1:0] bitmap_nx_s;
    logic [IDX_W-1:0]     ptr_nx_s;
    logic                 sel_valid_nx_s;
    logic [N_ENTRIES-1:0] sel_onehot_nx_s;
    logic [IDX_W-1:0]     sel_index_nx_s;
    logic [1:0]           sel_op_nx_s;

    logic                 req_ready_s;
    logic                 accept_s;
    logic                 full_s;
    logic [IDX_W-1:0]     free_idx_s;

    assign req_ready_s  = !i_flush && (!sel_valid_r || i_sel_ready);
    assign accept_s     = i_req_valid && req_ready_s;
    assign full_s       = &bitmap_r;

    assign o_req_ready  = req_ready_s;
    assign o_sel_valid  = sel_valid_r;
    assign o_sel_onehot = sel_onehot_r;
    assign o_sel_index  = sel_index_r;
    assign o_sel_op     = sel_op_r;
    assign o_valid_map  = bitmap_r;

    // Lowest-numbered clear bitmap bit; scanning downward lets the lowest win.
    always_comb begin
        free_idx_s = {IDX_W{1'b0}};
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!bitmap_r[i]) begin
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Next-state for the allocation state and the single result register.
    always_comb begin
        bitmap_nx_s     = bitmap_r;
        ptr_nx_s        = ptr_r;
        sel_valid_nx_s  = sel_valid_r;
        sel_onehot_nx_s = sel_onehot_r;
        sel_index_nx_s  = sel_index_r;
        sel_op_nx_s     = sel_op_r;
        if (i_flush) begin
            // Flush wins over any pending result and blocks acceptance.
            bitmap_nx_s     = {N_ENTRIES{1'b0}};
            ptr_nx_s        = {IDX_W{1'b0}};
            sel_valid_nx_s  = 1'b0;
            sel_onehot_nx_s = {N_ENTRIES{1'b0}};
            sel_index_nx_s  = {IDX_W{1'b0}};
            sel_op_nx_s     = 2'b00;
        end else if (accept_s) begin
            sel_valid_nx_s = 1'b1;
            sel_op_nx_s    = i_req_op;
            case (i_req_op)
                OP_HIT: begin
                    sel_index_nx_s  = i_req_index;
                    sel_onehot_nx_s = idx_to_onehot(i_req_index);
                end
                OP_ALLOC: begin
                    if (!full_s) begin
                        // Free slot available: pointer only moves on replacement.
                        sel_index_nx_s  = free_idx_s;
                        sel_onehot_nx_s = idx_to_onehot(free_idx_s);
                        bitmap_nx_s     = bitmap_r | idx_to_onehot(free_idx_s);
                    end else begin
                        // N_ENTRIES is a power of two, so the increment wraps naturally.
                        sel_index_nx_s  = ptr_r;
                        sel_onehot_nx_s = idx_to_onehot(ptr_r);
                        ptr_nx_s        = ptr_r + IDX_W'(1);
                    end
                end
                OP_INVAL: begin
                    sel_index_nx_s  = i_req_index;
                    sel_onehot_nx_s = idx_to_onehot(i_req_index);
                    bitmap_nx_s     = bitmap_r & ~idx_to_onehot(i_req_index);
                end
                default: begin
                    sel_index_nx_s  = {IDX_W{1'b0}};
                    sel_onehot_nx_s = {N_ENTRIES{1'b0}};
                end
            endcase
        end else if (sel_valid_r && i_sel_ready) begin
            // Result consumed with nothing new behind it.
            sel_valid_nx_s = 1'b0;
        end else begin
            sel_valid_nx_s = sel_valid_r;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap_r     <= {N_ENTRIES{1'b0}};
            ptr_r        <= {IDX_W{1'b0}};
            sel_valid_r  <= 1'b0;
            sel_onehot_r <= {N_ENTRIES{1'b0}};
            sel_index_r  <= {IDX_W{1'b0}};
            sel_op_r     <= 2'b00;
        end else begin
            bitmap_r     <= bitmap_nx_s;
            ptr_r        <= ptr_nx_s;
            sel_valid_r  <= sel_valid_nx_s;
            sel_onehot_r <= sel_onehot_nx_s;
            sel_index_r  <= sel_index_nx_s;
            sel_op_r     <= sel_op_nx_s;
        end
    end

endmodule

// File: tb/tb_victim_cache_slot_decoder.sv
// ---------------------------------------------------------------------------
// tb_victim_cache_slot_decoder
//
// Directed test of victim_cache_slot_decoder with N_ENTRIES = 16: fill,
// round-robin replacement and wrap, invalidate/reallocate, reserved op,
// back-pressure hold, flush over a pending result and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_victim_cache_slot_decoder;

    localparam int N_ENTRIES = 16;
    localparam int IDX_W     = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 i_flush;
    logic                 i_req_valid;
    logic                 o_req_ready;
    logic [1:0]           i_req_op;
    logic [IDX_W-1:0]     i_req_index;
    logic                 o_sel_valid;
    logic                 i_sel_ready;
    logic [N_ENTRIES-1:0] o_sel_onehot;
    logic [IDX_W-1:0]     o_sel_index;
    logic [1:0]           o_sel_op;
    logic [N_ENTRIES-1:0] o_valid_map;

    int n_checks;
    int n_errors;

    victim_cache_slot_decoder #(.N_ENTRIES(N_ENTRIES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (i_flush),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_op     (i_req_op),
        .i_req_index  (i_req_index),
        .o_sel_valid  (o_sel_valid),
        .i_sel_ready  (i_sel_ready),
        .o_sel_onehot (o_sel_onehot),
        .o_sel_index  (o_sel_index),
        .o_sel_op     (o_sel_op),
        .o_valid_map  (o_valid_map)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with no request and the consumer ready, draining any result.
    task automatic idle();
        i_req_valid = 1'b0;
        i_sel_ready = 1'b1;
        tick();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b1;
        i_flush     = 1'b0;
        i_req_valid = 1'b0;
        i_req_op    = 2'b00;
        i_req_index = 4'd0;
        i_sel_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid",  32'(o_sel_valid),  32'd0);
        chk("rst_onehot", 32'(o_sel_onehot), 32'd0);
        chk("rst_index",  32'(o_sel_index),  32'd0);
        chk("rst_op",     32'(o_sel_op),     32'd0);
        chk("rst_map",    32'(o_valid_map),  32'd0);
        chk("rst_ready",  32'(o_req_ready),  32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill: 16 back-to-back ALLOCs take entries 0..15 in order.
        i_req_valid = 1'b1;
        i_req_op    = 2'b01;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("fill_valid",  32'(o_sel_valid),  32'd1);
            chk("fill_index",  32'(o_sel_index),  32'(i));
            chk("fill_onehot", 32'(o_sel_onehot), 32'd1 << i);
            chk("fill_op",     32'(o_sel_op),     32'd1);
            chk("fill_map",    32'(o_valid_map),  (32'd1 << (i + 1)) - 32'd1);
        end
        chk("fill_map_full", 32'(o_valid_map), 32'h0000_ffff);

        // Full map: 17 ALLOCs replace 0..15 then wrap back to 0.
        for (int i = 0; i < 17; i++) begin
            tick();
            chk("rr_index",  32'(o_sel_index),  32'(i % 16));
            chk("rr_onehot", 32'(o_sel_onehot), 32'd1 << (i % 16));
        end
        chk("rr_map", 32'(o_valid_map), 32'h0000_ffff);
        idle();
        chk("drain_valid", 32'(o_sel_valid), 32'd0);

        // INVAL 5 twice, then ALLOC refills 5 without moving the pointer (now 1).
        i_req_valid = 1'b1;
        i_req_op    = 2'b10;
        i_req_index = 4'd5;
        tick();
        chk("inval_onehot", 32'(o_sel_onehot), 32'h0000_0020);
        chk("inval_index",  32'(o_sel_index),  32'd5);
        chk("inval_op",     32'(o_sel_op),     32'd2);
        chk("inval_map",    32'(o_valid_map),  32'h0000_ffdf);
        tick();
        chk("reinval_valid",  32'(o_sel_valid),  32'd1);
        chk("reinval_onehot", 32'(o_sel_onehot), 32'h0000_0020);
        chk("reinval_map",    32'(o_valid_map),  32'h0000_ffdf);
        i_req_op = 2'b01;
        tick();
        chk("realloc_index", 32'(o_sel_index), 32'd5);
        chk("realloc_map",   32'(o_valid_map), 32'h0000_ffff);
        tick();
        chk("ptr_kept_index", 32'(o_sel_index), 32'd1);

        // Reserved op: accepted, empty select, state untouched.
        i_req_op    = 2'b11;
        i_req_index = 4'd7;
        tick();
        chk("rsv_valid",  32'(o_sel_valid),  32'd1);
        chk("rsv_onehot", 32'(o_sel_onehot), 32'd0);
        chk("rsv_index",  32'(o_sel_index),  32'd0);
        chk("rsv_op",     32'(o_sel_op),     32'd3);
        chk("rsv_map",    32'(o_valid_map),  32'h0000_ffff);
        idle();

        // HIT 9 under back-pressure: result held, no acceptance.
        i_req_valid = 1'b1;
        i_req_op    = 2'b00;
        i_req_index = 4'd9;
        i_sel_ready = 1'b0;
        tick();
        chk("hit_valid",  32'(o_sel_valid),  32'd1);
        chk("hit_onehot", 32'(o_sel_onehot), 32'h0000_0200);
        chk("hit_index",  32'(o_sel_index),  32'd9);
        chk("hit_ready",  32'(o_req_ready),  32'd0);
        i_req_index = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_onehot", 32'(o_sel_onehot), 32'h0000_0200);
            chk("hold_index",  32'(o_sel_index),  32'd9);
            chk("hold_ready",  32'(o_req_ready),  32'd0);
            chk("hold_map",    32'(o_valid_map),  32'h0000_ffff);
        end

        // Flush over the pending result.
        i_flush = 1'b1;
        #1;
        chk("flush_ready", 32'(o_req_ready), 32'd0);
        tick();
        chk("flush_valid",  32'(o_sel_valid),  32'd0);
        chk("flush_onehot", 32'(o_sel_onehot), 32'd0);
        chk("flush_map",    32'(o_valid_map),  32'd0);
        i_flush     = 1'b0;
        i_sel_ready = 1'b1;
        i_req_op    = 2'b01;
        tick();
        chk("post_flush_index", 32'(o_sel_index), 32'd0);
        chk("post_flush_map",   32'(o_valid_map), 32'h0000_0001);
        // 15 more fill the map; the 16th replaces at the pointer, which flush reset to 0.
        for (int k = 1; k <= 16; k++) begin
            tick();
        end
        chk("flush_ptr_index", 32'(o_sel_index), 32'd0);
        chk("flush_ptr_map",   32'(o_valid_map), 32'h0000_ffff);

        // Asynchronous reset with a result pending.
        i_req_op    = 2'b00;
        i_req_index = 4'd3;
        tick();
        chk("pre_rst_onehot", 32'(o_sel_onehot), 32'h0000_0008);
        i_req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",  32'(o_sel_valid),  32'd0);
        chk("arst_onehot", 32'(o_sel_onehot), 32'd0);
        chk("arst_index",  32'(o_sel_index),  32'd0);
        chk("arst_op",     32'(o_sel_op),     32'd0);
        chk("arst_map",    32'(o_valid_map),  32'd0);
        tick();
        rst_n       = 1'b1;
        i_req_valid = 1'b1;
        i_req_op    = 2'b01;
        tick();
        chk("first_after_rst_valid", 32'(o_sel_valid), 32'd1);
        chk("first_after_rst_index", 32'(o_sel_index), 32'd0);
        chk("first_after_rst_map",   32'(o_valid_map), 32'h0000_0001);
        i_req_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
